// File: rtl/pool_pkg.sv
// Shared encodings for the temporal pooling stage: mode, window and FSM state.
// Latency: none (types, constants and pure functions only).
// Backpressure: not applicable.
package pool_pkg;

  // pool_select encodings
  localparam logic POOL_MAX = 1'b0;
  localparam logic POOL_AVG = 1'b1;

  // pool_window encodings; the reserved code behaves as a 4-beat window
  localparam logic [1:0] WIN_1   = 2'd0;
  localparam logic [1:0] WIN_2   = 2'd1;
  localparam logic [1:0] WIN_4   = 2'd2;
  localparam logic [1:0] WIN_RSV = 2'd3;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ACCUM = 2'd1,
    ST_DONE  = 2'd2
  } state_t;

  // Per-tile configuration captured on the first beat
  typedef struct packed {
    logic       sel;
    logic [1:0] win;
  } cfg_t;

  // log2 of the window length, used as the average shift amount
  function automatic logic [1:0] win_log2(input logic [1:0] win);
    case (win)
      WIN_1:   win_log2 = 2'd0;
      WIN_2:   win_log2 = 2'd1;
      default: win_log2 = 2'd2;
    endcase
  endfunction

  // Window length in beats
  function automatic logic [2:0] win_size(input logic [1:0] win);
    case (win)
      WIN_1:   win_size = 3'd1;
      WIN_2:   win_size = 3'd2;
      default: win_size = 3'd4;
    endcase
  endfunction

endpackage

// File: rtl/pool_lane.sv
// One lane of the pooling stage: running max or sum over the current window.
// Latency: result is combinational on the current beat; the top registers it.
// Backpressure: none; every qualified beat is absorbed in the cycle it arrives.
module pool_lane
  import pool_pkg::*;
#(
  parameter int DWIDTH = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              clr,
  input  logic              beat,
  input  logic              first,
  input  logic              sel,
  input  logic [1:0]        shamt,
  input  logic              lane_vld,
  input  logic [DWIDTH-1:0] din,
  output logic [DWIDTH-1:0] res
);

  // Two guard bits hold a 4-beat sum of DWIDTH-bit values without overflow
  logic signed [DWIDTH+1:0] acc;
  logic signed [DWIDTH+1:0] acc_nxt;
  logic signed [DWIDTH+1:0] din_ext;

  // Next accumulator value including this beat, and the lane result derived from it
  always_comb begin
    din_ext = $signed({{2{din[DWIDTH-1]}}, din});
    acc_nxt = acc;
    if (first) begin
      acc_nxt = din_ext;
    end else if (sel == POOL_AVG) begin
      acc_nxt = acc + din_ext;
    end else if (din_ext > acc) begin
      acc_nxt = din_ext;
    end
    res = '0;
    if (lane_vld) begin
      // Arithmetic shift floors toward minus infinity, as the average requires
      res = (sel == POOL_AVG) ? DWIDTH'(acc_nxt >>> shamt) : DWIDTH'(acc_nxt);
    end
  end

  // Accumulator advances only on accepted beats; a bypass period wipes it
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      acc <= '0;
    end else if (clr) begin
      acc <= '0;
    end else if (beat) begin
      acc <= acc_nxt;
    end
  end

endmodule

// File: rtl/pool.sv
// Per-lane temporal max/average pooling over windows of 1, 2 or 4 beats per tile.
// Latency: one output pulse 1 cycle after each window-closing beat; bypass is combinational.
// Backpressure: none; a beat is accepted every cycle in_data_available is high, gaps hold state.
module pool
  import pool_pkg::*;
#(
  parameter int DESIGN_SIZE = 4,
  parameter int DWIDTH      = 8,
  parameter int MASK_WIDTH  = DESIGN_SIZE
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          enable_pool,
  input  logic                          pool_select,
  input  logic [1:0]                    pool_window,
  input  logic [MASK_WIDTH-1:0]         validity_mask,
  input  logic                          in_data_available,
  input  logic [DESIGN_SIZE*DWIDTH-1:0] inp_data,
  output logic [DESIGN_SIZE*DWIDTH-1:0] out_data,
  output logic                          out_data_available,
  output logic                          done_pool
);

  localparam int CW = $clog2(DESIGN_SIZE + 1);

  state_t                        state;
  logic [CW-1:0]                 beat_cnt;
  logic [2:0]                    win_cnt;
  cfg_t                          cfg;
  logic [MASK_WIDTH-1:0]         cfg_mask;
  logic [DESIGN_SIZE*DWIDTH-1:0] out_reg;
  logic                          out_vld_reg;
  logic                          done_reg;

  logic                          beat;
  logic                          start;
  logic                          first;
  logic                          close;
  logic                          last;
  cfg_t                          eff_cfg;
  logic [MASK_WIDTH-1:0]         eff_mask;
  logic [1:0]                    shamt;
  logic [CW-1:0]                 bc_nxt;
  logic [2:0]                    wc_nxt;
  logic [DESIGN_SIZE*DWIDTH-1:0] lane_res;

  // Beat qualification, window/tile boundary detection and the config in force this beat.
  // A tile's first beat must already use the incoming config, hence the start-time bypass
  // of the latched copy.
  always_comb begin
    beat     = enable_pool & in_data_available;
    start    = beat && (state != ST_ACCUM);
    eff_cfg  = start ? cfg_t'{sel: pool_select, win: pool_window} : cfg;
    eff_mask = start ? validity_mask : cfg_mask;
    shamt    = win_log2(eff_cfg.win);
    bc_nxt   = (start ? '0 : beat_cnt) + CW'(1);
    wc_nxt   = (start ? 3'd0 : win_cnt) + 3'd1;
    first    = start || (win_cnt == 3'd0);
    last     = beat && (bc_nxt == CW'(DESIGN_SIZE));
    close    = beat && ((wc_nxt == win_size(eff_cfg.win)) || last);
  end

  for (genvar i = 0; i < DESIGN_SIZE; i++) begin : g_lane
    pool_lane #(
      .DWIDTH(DWIDTH)
    ) u_lane (
      .clk      (clk),
      .reset    (reset),
      .clr      (~enable_pool),
      .beat     (beat),
      .first    (first),
      .sel      (eff_cfg.sel),
      .shamt    (shamt),
      .lane_vld (eff_mask[i]),
      .din      (inp_data[i*DWIDTH +: DWIDTH]),
      .res      (lane_res[i*DWIDTH +: DWIDTH])
    );
  end

  // Tile FSM with counters, config latch and registered outputs; disabling drops the tile
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state       <= ST_IDLE;
      beat_cnt    <= '0;
      win_cnt     <= '0;
      cfg         <= '0;
      cfg_mask    <= '0;
      out_reg     <= '0;
      out_vld_reg <= 1'b0;
      done_reg    <= 1'b0;
    end else if (!enable_pool) begin
      state       <= ST_IDLE;
      beat_cnt    <= '0;
      win_cnt     <= '0;
      cfg         <= '0;
      cfg_mask    <= '0;
      out_reg     <= '0;
      out_vld_reg <= 1'b0;
      done_reg    <= 1'b0;
    end else begin
      out_vld_reg <= close;
      if (close) begin
        out_reg <= lane_res;
      end
      if (beat) begin
        if (start) begin
          cfg.sel  <= pool_select;
          cfg.win  <= pool_window;
          cfg_mask <= validity_mask;
        end
        beat_cnt <= last ? '0 : bc_nxt;
        win_cnt  <= close ? 3'd0 : wc_nxt;
        // Rises with the final pulse; any later first beat clears it
        done_reg <= last;
        state    <= last ? ST_DONE : ST_ACCUM;
      end
    end
  end

  // Bypass mux: with pooling off the norm output flows straight through
  always_comb begin
    out_data           = enable_pool ? out_reg     : inp_data;
    out_data_available = enable_pool ? out_vld_reg : in_data_available;
    done_pool          = enable_pool ? done_reg    : 1'b1;
  end

endmodule

// File: tb/tb_pool.sv
// Self-checking bench for pool: directed scenarios plus randomized tiles vs a reference model.
// Latency: pulses are matched to the cycle of the beat that closes each window.
// Backpressure: none exercised; the DUT has no ready signal.
module tb_pool;

  logic        clk;
  logic        reset;
  logic        enable_pool;
  logic        pool_select;
  logic [1:0]  pool_window;
  logic [3:0]  validity_mask;
  logic        in_data_available;
  logic [31:0] inp_data;
  logic [31:0] out_data;
  logic        out_data_available;
  logic        done_pool;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  logic [31:0] tile_dat [4];
  int          beat_cyc [$];
  logic [31:0] cap_dat  [$];
  int          cap_cyc  [$];
  logic        cap_done [$];
  logic [31:0] exp_dat  [$];
  int          exp_beat [$];
  logic        exp_done [$];

  pool #(
    .DESIGN_SIZE(4),
    .DWIDTH     (8),
    .MASK_WIDTH (4)
  ) dut (
    .clk               (clk),
    .reset             (reset),
    .enable_pool       (enable_pool),
    .pool_select       (pool_select),
    .pool_window       (pool_window),
    .validity_mask     (validity_mask),
    .in_data_available (in_data_available),
    .inp_data          (inp_data),
    .out_data          (out_data),
    .out_data_available(out_data_available),
    .done_pool         (done_pool)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Record every pooled output pulse with the cycle it appeared in
  always @(negedge clk) begin
    if (enable_pool === 1'b1 && out_data_available === 1'b1) begin
      cap_dat.push_back(out_data);
      cap_cyc.push_back(cyc);
      cap_done.push_back(done_pool);
    end
  end

  task automatic clear_q();
    beat_cyc.delete(); cap_dat.delete(); cap_cyc.delete(); cap_done.delete();
    exp_dat.delete(); exp_beat.delete(); exp_done.delete();
  endtask

  // Reference: per window, max or floored mean of each lane, masked lanes zero
  task automatic model_tile(input logic sel, input logic [1:0] win, input logic [3:0] mask);
    int k, base, hi, acc, v;
    logic [31:0] col;
    base = beat_cyc.size();
    k = (win == 2'd0) ? 1 : (win == 2'd1) ? 2 : 4;
    for (int lo = 0; lo < 4; lo += k) begin
      hi = (lo + k > 4) ? 4 : lo + k;
      col = '0;
      for (int l = 0; l < 4; l++) begin
        acc = sel ? 0 : -1000;
        for (int b = lo; b < hi; b++) begin
          v = $signed(tile_dat[b][l*8 +: 8]);
          acc = sel ? acc + v : ((v > acc) ? v : acc);
        end
        if (sel) begin
          v = acc / k;
          if ((acc % k) != 0 && acc < 0) v = v - 1;
          acc = v;
        end
        if (!mask[l]) acc = 0;
        col[l*8 +: 8] = acc[7:0];
      end
      exp_dat.push_back(col);
      exp_beat.push_back(base + hi - 1);
      exp_done.push_back(hi == 4);
    end
  endtask

  // Drive one tile; config wiggles randomly after the first beat and must be ignored
  task automatic drive_tile(input logic sel, input logic [1:0] win, input logic [3:0] mask,
                            input int gap);
    for (int b = 0; b < 4; b++) begin
      in_data_available = 1'b1;
      inp_data = tile_dat[b];
      if (b == 0) begin
        pool_select = sel; pool_window = win; validity_mask = mask;
      end else begin
        pool_select = 1'($urandom); pool_window = 2'($urandom); validity_mask = 4'($urandom);
      end
      @(posedge clk); #1;
      beat_cyc.push_back(cyc);
      in_data_available = 1'b0;
      inp_data = 32'($urandom);
      for (int g = 0; g < gap; g++) begin
        @(posedge clk); #1;
      end
    end
  endtask

  task automatic settle();
    @(negedge clk); @(posedge clk); #1;
  endtask

  task automatic rand_tile();
    for (int b = 0; b < 4; b++) tile_dat[b] = 32'($urandom);
  endtask

  task automatic test_reset();
    #2;
    checks++;
    if (out_data !== 32'h0 || out_data_available !== 1'b0 || done_pool !== 1'b0) begin
      errors++;
      $display("FAIL reset_state: got data=%h avail=%b done=%b want 0/0/0",
               out_data, out_data_available, done_pool);
    end
    @(posedge clk); #1;
    reset = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_bypass();
    enable_pool = 1'b0;
    in_data_available = 1'b1;
    inp_data = 32'h01020304;
    #1;
    checks++;
    if (out_data !== 32'h01020304 || out_data_available !== 1'b1 || done_pool !== 1'b1) begin
      errors++;
      $display("FAIL bypass_on: got data=%h avail=%b done=%b want 01020304/1/1",
               out_data, out_data_available, done_pool);
    end
    in_data_available = 1'b0;
    inp_data = 32'hA5C3_0F81;
    #1;
    checks++;
    if (out_data !== 32'hA5C3_0F81 || out_data_available !== 1'b0) begin
      errors++;
      $display("FAIL bypass_idle: got data=%h avail=%b want a5c30f81/0",
               out_data, out_data_available);
    end
    @(posedge clk); #1;
    enable_pool = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_max_k2();
    clear_q();
    tile_dat[0] = {24'($urandom), 8'd3};
    tile_dat[1] = {24'($urandom), 8'hFB};
    tile_dat[2] = {24'($urandom), 8'd7};
    tile_dat[3] = {24'($urandom), 8'd2};
    drive_tile(1'b0, 2'd1, 4'hF, 0);
    settle();
    checks++;
    if (cap_dat.size() != 2) begin
      errors++;
      $display("FAIL max_k2_count: got %0d pulses want 2", cap_dat.size());
    end else begin
      checks++;
      if (cap_dat[0][7:0] !== 8'd3 || cap_dat[1][7:0] !== 8'd7) begin
        errors++;
        $display("FAIL max_k2_value: got %h,%h want 03,07", cap_dat[0][7:0], cap_dat[1][7:0]);
      end
      checks++;
      if (cap_cyc[0] != beat_cyc[1] || cap_cyc[1] != beat_cyc[3]) begin
        errors++;
        $display("FAIL max_k2_latency: got cyc %0d,%0d want %0d,%0d",
                 cap_cyc[0], cap_cyc[1], beat_cyc[1], beat_cyc[3]);
      end
      checks++;
      if (cap_done[0] !== 1'b0 || cap_done[1] !== 1'b1) begin
        errors++;
        $display("FAIL max_k2_done: got %b,%b want 0,1", cap_done[0], cap_done[1]);
      end
    end
    checks++;
    if (done_pool !== 1'b1) begin
      errors++;
      $display("FAIL max_k2_done_hold: got %b want 1", done_pool);
    end
  endtask

  task automatic test_avg_k4();
    clear_q();
    tile_dat[0] = {16'($urandom), 8'hFF, 8'd10};
    tile_dat[1] = {16'($urandom), 8'hFE, 8'd20};
    tile_dat[2] = {16'($urandom), 8'hFD, 8'd30};
    tile_dat[3] = {16'($urandom), 8'hFC, 8'hFF};
    drive_tile(1'b1, 2'd2, 4'hF, 0);
    settle();
    checks++;
    if (cap_dat.size() != 1) begin
      errors++;
      $display("FAIL avg_k4_count: got %0d pulses want 1", cap_dat.size());
    end else begin
      checks++;
      if (cap_dat[0][15:0] !== 16'hFD0E) begin
        errors++;
        $display("FAIL avg_k4_value: got lane1/0=%h want fd0e", cap_dat[0][15:0]);
      end
      checks++;
      if (cap_cyc[0] != beat_cyc[3] || cap_done[0] !== 1'b1) begin
        errors++;
        $display("FAIL avg_k4_timing: got cyc=%0d done=%b want cyc=%0d done=1",
                 cap_cyc[0], cap_done[0], beat_cyc[3]);
      end
    end
  endtask

  task automatic test_k1_mask();
    clear_q();
    rand_tile();
    model_tile(1'b0, 2'd0, 4'b0111);
    drive_tile(1'b0, 2'd0, 4'b0111, 0);
    settle();
    checks++;
    if (cap_dat.size() != exp_dat.size()) begin
      errors++;
      $display("FAIL k1_mask_count: got %0d pulses want %0d", cap_dat.size(), exp_dat.size());
    end
    for (int i = 0; i < exp_dat.size() && i < cap_dat.size(); i++) begin
      checks++;
      if (cap_dat[i] !== exp_dat[i] || cap_cyc[i] != beat_cyc[exp_beat[i]] || cap_done[i] !== exp_done[i]) begin
        errors++;
        $display("FAIL k1_mask pulse %0d: got dat=%h cyc=%0d done=%b want dat=%h cyc=%0d done=%b",
                 i, cap_dat[i], cap_cyc[i], cap_done[i], exp_dat[i], beat_cyc[exp_beat[i]], exp_done[i]);
      end
    end
  endtask

  task automatic test_gaps();
    clear_q();
    rand_tile();
    model_tile(1'b0, 2'd2, 4'hF);
    drive_tile(1'b0, 2'd2, 4'hF, 2);
    settle();
    checks++;
    if (cap_dat.size() != exp_dat.size()) begin
      errors++;
      $display("FAIL gaps_count: got %0d pulses want %0d", cap_dat.size(), exp_dat.size());
    end
    for (int i = 0; i < exp_dat.size() && i < cap_dat.size(); i++) begin
      checks++;
      if (cap_dat[i] !== exp_dat[i] || cap_cyc[i] != beat_cyc[exp_beat[i]] || cap_done[i] !== exp_done[i]) begin
        errors++;
        $display("FAIL gaps pulse %0d: got dat=%h cyc=%0d done=%b want dat=%h cyc=%0d done=%b",
                 i, cap_dat[i], cap_cyc[i], cap_done[i], exp_dat[i], beat_cyc[exp_beat[i]], exp_done[i]);
      end
    end
  endtask

  task automatic test_reset_midtile();
    clear_q();
    tile_dat[0] = 32'h11223344;
    tile_dat[1] = 32'h55667788;
    for (int b = 0; b < 2; b++) begin
      in_data_available = 1'b1; inp_data = tile_dat[b];
      pool_select = 1'b0; pool_window = 2'd0; validity_mask = 4'hF;
      @(posedge clk); #1;
    end
    in_data_available = 1'b0;
    reset = 1'b0;
    #1;
    checks++;
    if (out_data !== 32'h0 || out_data_available !== 1'b0 || done_pool !== 1'b0) begin
      errors++;
      $display("FAIL reset_midtile: got data=%h avail=%b done=%b want 0/0/0",
               out_data, out_data_available, done_pool);
    end
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b1;
    clear_q();
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (cap_dat.size() != 0) begin
      errors++;
      $display("FAIL reset_no_pulse: got %0d pulses want 0", cap_dat.size());
    end
    rand_tile();
    model_tile(1'b1, 2'd1, 4'hF);
    drive_tile(1'b1, 2'd1, 4'hF, 0);
    settle();
    checks++;
    if (cap_dat.size() != exp_dat.size()) begin
      errors++;
      $display("FAIL reset_fresh_count: got %0d pulses want %0d", cap_dat.size(), exp_dat.size());
    end
    for (int i = 0; i < exp_dat.size() && i < cap_dat.size(); i++) begin
      checks++;
      if (cap_dat[i] !== exp_dat[i] || cap_cyc[i] != beat_cyc[exp_beat[i]] || cap_done[i] !== exp_done[i]) begin
        errors++;
        $display("FAIL reset_fresh pulse %0d: got dat=%h cyc=%0d done=%b want dat=%h cyc=%0d done=%b",
                 i, cap_dat[i], cap_cyc[i], cap_done[i], exp_dat[i], beat_cyc[exp_beat[i]], exp_done[i]);
      end
    end
  endtask

  task automatic test_disable_midtile();
    clear_q();
    for (int b = 0; b < 2; b++) begin
      in_data_available = 1'b1; inp_data = 32'($urandom);
      pool_select = 1'b1; pool_window = 2'd2; validity_mask = 4'hF;
      @(posedge clk); #1;
    end
    enable_pool = 1'b0;
    inp_data = 32'hDEAD_BEEF;
    #1;
    checks++;
    if (out_data !== 32'hDEAD_BEEF || done_pool !== 1'b1 || out_data_available !== 1'b1) begin
      errors++;
      $display("FAIL disable_bypass: got data=%h avail=%b done=%b want deadbeef/1/1",
               out_data, out_data_available, done_pool);
    end
    @(posedge clk); #1;
    in_data_available = 1'b0;
    enable_pool = 1'b1;
    #1;
    checks++;
    if (done_pool !== 1'b0 || out_data_available !== 1'b0) begin
      errors++;
      $display("FAIL disable_cleared: got avail=%b done=%b want 0/0", out_data_available, done_pool);
    end
    clear_q();
    rand_tile();
    model_tile(1'b1, 2'd2, 4'b1011);
    drive_tile(1'b1, 2'd2, 4'b1011, 1);
    settle();
    checks++;
    if (cap_dat.size() != exp_dat.size()) begin
      errors++;
      $display("FAIL disable_restart_count: got %0d pulses want %0d", cap_dat.size(), exp_dat.size());
    end
    for (int i = 0; i < exp_dat.size() && i < cap_dat.size(); i++) begin
      checks++;
      if (cap_dat[i] !== exp_dat[i] || cap_cyc[i] != beat_cyc[exp_beat[i]] || cap_done[i] !== exp_done[i]) begin
        errors++;
        $display("FAIL disable_restart pulse %0d: got dat=%h cyc=%0d done=%b want dat=%h cyc=%0d done=%b",
                 i, cap_dat[i], cap_cyc[i], cap_done[i], exp_dat[i], beat_cyc[exp_beat[i]], exp_done[i]);
      end
    end
  endtask

  // Random tiles; a zero gap makes the next tile's first beat land on the final pulse
  task automatic test_random_back_to_back();
    logic       sel;
    logic [1:0] win;
    logic [3:0] mask;
    clear_q();
    for (int t = 0; t < 30; t++) begin
      rand_tile();
      sel  = 1'($urandom);
      win  = 2'($urandom);
      mask = 4'($urandom);
      model_tile(sel, win, mask);
      drive_tile(sel, win, mask, (t % 3 == 0) ? 0 : $urandom_range(0, 2));
    end
    settle();
    checks++;
    if (cap_dat.size() != exp_dat.size()) begin
      errors++;
      $display("FAIL random_count: got %0d pulses want %0d", cap_dat.size(), exp_dat.size());
    end
    for (int i = 0; i < exp_dat.size() && i < cap_dat.size(); i++) begin
      checks++;
      if (cap_dat[i] !== exp_dat[i] || cap_cyc[i] != beat_cyc[exp_beat[i]] || cap_done[i] !== exp_done[i]) begin
        errors++;
        $display("FAIL random pulse %0d: got dat=%h cyc=%0d done=%b want dat=%h cyc=%0d done=%b",
                 i, cap_dat[i], cap_cyc[i], cap_done[i], exp_dat[i], beat_cyc[exp_beat[i]], exp_done[i]);
      end
    end
    checks++;
    if (done_pool !== 1'b1) begin
      errors++;
      $display("FAIL random_done_hold: got %b want 1", done_pool);
    end
  endtask

  initial begin
    clk = 1'b0;
    reset = 1'b0;
    enable_pool = 1'b1;
    pool_select = 1'b0;
    pool_window = 2'd0;
    validity_mask = 4'hF;
    in_data_available = 1'b0;
    inp_data = '0;
    test_reset();
    test_bypass();
    test_max_k2();
    test_avg_k4();
    test_k1_mask();
    test_gaps();
    test_reset_midtile();
    test_disable_midtile();
    test_random_back_to_back();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/pool.md
# pool

Per-lane temporal pooling stage fed by the normalization stage's output columns. Each input beat is one column of `DESIGN_SIZE` signed elements, one per lane. For each lane, the block reduces every window of k consecutive beats to one value, either max or average. It emits one output column per window and flags completion of the tile. When disabled it is a combinational bypass, so the activation stage downstream sees the norm output unchanged.

## Interface
Parameters:
- DESIGN_SIZE, 4, lanes per beat and beats per tile
- DWIDTH, 8, signed element width
- MASK_WIDTH, DESIGN_SIZE, validity mask width

Ports:
- clk  input  1  clock; all state updates on the rising edge
- reset  input  1  asynchronous, active-low reset
- enable_pool  input  1  0 selects bypass
- pool_select  input  1  0 = max, 1 = average
- pool_window  input  2  window size: 0→1, 1→2, 2→4, 3→4 (reserved)
- validity_mask  input  MASK_WIDTH  1 = lane valid
- in_data_available  input  1  inp_data holds a valid beat this cycle
- inp_data  input  DESIGN_SIZE*DWIDTH  lane i at [i*DWIDTH +: DWIDTH]
- out_data  output  DESIGN_SIZE*DWIDTH  pooled column
- out_data_available  output  1  out_data valid this cycle
- done_pool  output  1  tile complete

## Operation
- Bypass (enable_pool=0):
  - out_data = inp_data, out_data_available = in_data_available, done_pool = 1, all combinational.
  - Internal state is cleared synchronously.
- State machine: IDLE → ACCUM → DONE.
  - IDLE: on the first beat, latch pool_select, pool_window and validity_mask for the whole tile, load the lane accumulators, set beat_cnt=1 and win_cnt=1, go to ACCUM.
  - ACCUM: each beat increments beat_cnt and win_cnt and updates the accumulators.
    - When win_cnt reaches k, or beat_cnt reaches DESIGN_SIZE, register the result and reset win_cnt.
    - When beat_cnt reaches DESIGN_SIZE, go to DONE.
  - DONE: done_pool=1. A new beat starts the next tile exactly as IDLE would, in the same cycle, and done_pool drops.
- Config inputs are ignored after the first beat of a tile.
- Cycles with in_data_available=0 are gaps: accumulators, counters and state hold. Gaps are legal anywhere.
- Max mode:
  - The first beat of a window loads the element.
  - Later beats keep the signed maximum.
- Average mode:
  - Per-lane sum in DWIDTH+2 signed bits.
  - Result = sum >>> log2(k), arithmetic shift, rounding toward −∞, truncated to DWIDTH. No overflow is possible.
- Partial final window (k does not divide DESIGN_SIZE): emitted at the last beat. Average still shifts by log2(k).
- Masked lane (latched mask bit 0): output lane is 0.

## Timing
- Reset values: out_data=0, out_data_available=0, done_pool=0 (when enable_pool=1), state=IDLE, counters=0.
- Latency: out_data_available pulses 1 cycle after the beat that closes a window.
  - The pulse lasts exactly 1 cycle and out_data is valid only while it is high.
  - Between pulses, out_data holds its last value.
- done_pool rises in the same cycle as the final output pulse.
  - It holds until the next tile's first beat, enable_pool=0, or reset.
- Output count per tile: ceil(DESIGN_SIZE/k) pulses.
- Back-to-back tiles: a new tile's first beat arriving in the same cycle as the final output pulse is accepted with no bubble.
- Reset asserted mid-tile: the tile is discarded immediately and asynchronously. No output pulse follows reset release.
- enable_pool falling mid-tile: the tile is discarded. Re-enabling starts in IDLE.

## Structure
- Shared package holds:
  - POOL_MAX and POOL_AVG encodings.
  - pool_window encodings and the window-to-log2 mapping.
  - State enum for IDLE, ACCUM and DONE.
- One sub-module, `pool_lane`: per-lane max/sum accumulator with first-beat load, mask zeroing and result shift. It is instantiated DESIGN_SIZE times.
- The top level holds the FSM, counters, config latches and bypass mux.

## Test plan
DESIGN_SIZE=4, DWIDTH=8.
- Bypass: enable_pool=0, beat 0x01020304 → out_data identical in the same cycle, out_data_available follows input, done_pool=1.
- Max, k=2: lane0 beats 3, −5, 7, 2 → pulses 1 cycle after beats 2 and 4 carrying 3 then 7; done_pool rises with the second pulse.
- Average, k=4: lane0 beats 10, 20, 30, −1 → single pulse with 14. Lane1 beats −1, −2, −3, −4 → −3.
- k=1 with validity_mask=0b0111: 4 registered pulses of latency 1, lane3 always 0. pool_window changed after beat 1 has no effect.
- Gaps: max, k=4, beats with 2-cycle gaps between each → one pulse after beat 4 with the correct max. No early pulse.
- Reset: reset low after beat 2 of a tile → all outputs 0 immediately. After release, a fresh 4-beat tile yields correct results and a single done_pool.
